// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: operation launch, HI/LO write and result bundle between the pipeline and the mul/div sequencer
interface muldiv_seq_if #(parameter int DW = 32);
  logic          start;
  logic [1:0]    op;
  logic [DW-1:0] in1;
  logic [DW-1:0] in2;
  logic          flush;
  logic          hi_we;
  logic          lo_we;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;
  modport master (
    output start, op, in1, in2, flush, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );
  modport slave (
    input  start, op, in1, in2, flush, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MIPS MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair
module muldiv_seq #(
  parameter int DW    = 32,
  parameter int CNT_W = 6
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              s1_q, s1_d, s2_q, s2_d, dz_q, dz_d;
  logic              done_q, done_d, dbz_q, dbz_d;
  logic [DW-1:0]     acc_q, acc_d, low_q, low_d, opnd_q, opnd_d;
  logic [DW-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic              is_div, sgn, dz_now;
  logic [DW:0]       shl, add_a, add_b;
  logic [DW+1:0]     add_sum;
  logic [DW-1:0]     m1, m2;
  logic [2*DW-1:0]   prod;
  // Shared 33-bit adder: multiply accumulate, or trial subtract (a + ~b + 1) whose carry-out means no borrow
  always_comb begin
    is_div  = op_q[1];
    shl     = {acc_q, low_q[DW-1]};
    add_a   = is_div ? shl : {1'b0, acc_q};
    add_b   = is_div ? ~{1'b0, opnd_q} : (low_q[0] ? {1'b0, opnd_q} : '0);
    add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(DW+1){1'b0}}, is_div};
    prod    = (s1_q ^ s2_q) ? -{acc_q, low_q} : {acc_q, low_q};
    sgn     = !bus.op[0];
    m1      = (sgn && bus.in1[DW-1]) ? -bus.in1 : bus.in1;
    m2      = (sgn && bus.in2[DW-1]) ? -bus.in2 : bus.in2;
    dz_now  = bus.op[1] && (bus.in2 == '0);
  end
  // Next-state, datapath iteration, sign fixup and HI/LO update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dz_d    = dz_q;
    acc_d   = acc_q;
    low_d   = low_q;
    opnd_d  = opnd_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (bus.start && !bus.flush) begin
          op_d    = bus.op;
          s1_d    = sgn && bus.in1[DW-1];
          s2_d    = sgn && bus.in2[DW-1];
          dz_d    = dz_now;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          acc_d   = dz_now ? bus.in1 : '0;
          low_d   = bus.op[1] ? m1 : m2;
          opnd_d  = bus.op[1] ? m2 : m1;
          state_d = dz_now ? FIXUP : CALC;
        end
      end
      CALC: begin
        cnt_d   = cnt_q + 1'b1;
        acc_d   = is_div ? (add_sum[DW+1] ? add_sum[DW-1:0] : shl[DW-1:0]) : add_sum[DW:1];
        low_d   = is_div ? {low_q[DW-2:0], add_sum[DW+1]} : {add_sum[0], low_q[DW-1:1]};
        state_d = (cnt_q == CNT_W'(DW-1)) ? FIXUP : CALC;
      end
      FIXUP: begin
        state_d = IDLE;
        done_d  = 1'b1;
        dbz_d   = dz_q;
        hi_d    = dz_q ? acc_q : is_div ? (s1_q ? -acc_q : acc_q) : prod[2*DW-1:DW];
        lo_d    = dz_q ? '1 : is_div ? ((s1_q ^ s2_q) ? -low_q : low_q) : prod[DW-1:0];
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end
  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      dz_q    <= 1'b0;
      acc_q   <= '0;
      low_q   <= '0;
      opnd_q  <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dz_q    <= dz_d;
      acc_q   <= acc_d;
      low_q   <= low_d;
      opnd_q  <= opnd_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign bus.busy        = state_q != IDLE;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule
